// File: rtl/soil_moisture_classifier_pkg.sv
// Shared soil-condition class encoding and classifier FSM states.
// The pump controller imports the same class constants.
package soil_moisture_classifier_pkg;

  typedef logic [1:0] soil_class_t;

  localparam soil_class_t CLASS_DRY     = 2'b00;
  localparam soil_class_t CLASS_OPTIMAL = 2'b01;
  localparam soil_class_t CLASS_WET     = 2'b10;
  localparam soil_class_t CLASS_FAULT   = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

endpackage

// File: rtl/soil_moisture_classifier_window_averager.sv
// Fixed-length window accumulator: presents the window mean, done strobe and
// rail flag combinationally in the cycle the final sample is accepted.
module soil_moisture_classifier_window_averager #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                done_c,
  output logic [SAMPLE_W-1:0] mean_c,
  output logic                rail_c
);

  localparam int unsigned ACC_W   = SAMPLE_W + AVG_LOG2;
  localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned AVG_LEN = 2 ** AVG_LOG2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt;
  logic             rail_acc;
  logic             last_c;
  logic             sample_rail_c;

  always_comb begin
    sum_c         = acc + ACC_W'(sample);
    last_c        = (cnt == CNT_W'(AVG_LEN - 1));
    done_c        = sample_valid & ~flush & last_c;
    mean_c        = SAMPLE_W'(sum_c >> AVG_LOG2);
    sample_rail_c = (sample == '0) | (sample == '1);
    rail_c        = rail_acc | sample_rail_c;
  end

  // Accumulator restarts on the cycle after the last sample; flush drops the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      rail_acc <= 1'b0;
    end else if (flush) begin
      acc      <= '0;
      cnt      <= '0;
      rail_acc <= 1'b0;
    end else if (sample_valid) begin
      if (last_c) begin
        acc      <= '0;
        cnt      <= '0;
        rail_acc <= 1'b0;
      end else begin
        acc      <= sum_c;
        cnt      <= cnt + CNT_W'(1);
        rail_acc <= rail_c;
      end
    end
  end

endmodule

// File: rtl/soil_moisture_classifier.sv
// Soil moisture classifier: window-averaged ADC samples classified with hysteresis
// and N-window confirmation. Optional sensor rail fault: SOIL_SENSOR_FAULT_EN.
module soil_moisture_classifier
  import soil_moisture_classifier_pkg::*;
#(
  parameter int unsigned SAMPLE_W      = 12,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned DRY_THR       = 1000,
  parameter int unsigned WET_THR       = 3000,
  parameter int unsigned HYST          = 100,
  parameter int unsigned CONFIRM_N     = 2,
  parameter int unsigned FAULT_WINDOWS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                flush,
  output soil_class_t         soil_class,
  output logic                class_valid,
  output logic                class_changed,
  output logic [SAMPLE_W-1:0] window_mean,
  output logic                fault
);

  localparam int unsigned CW    = SAMPLE_W + 1;
  localparam int unsigned CNT_W = $clog2(CONFIRM_N + 1);

  localparam logic [CW-1:0] DRY_LO = CW'(DRY_THR - HYST);
  localparam logic [CW-1:0] DRY_HI = CW'(DRY_THR + HYST);
  localparam logic [CW-1:0] WET_LO = CW'(WET_THR - HYST);
  localparam logic [CW-1:0] WET_HI = CW'(WET_THR + HYST);
  localparam logic [CW-1:0] DRY_C  = CW'(DRY_THR);
  localparam logic [CW-1:0] WET_C  = CW'(WET_THR);

  logic                done_c;
  logic [SAMPLE_W-1:0] mean_c;
  logic                rail_c;

  soil_moisture_classifier_window_averager #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .sample_valid (sample_valid),
    .sample       (sample),
    .done_c       (done_c),
    .mean_c       (mean_c),
    .rail_c       (rail_c)
  );

  state_t              state, state_n;
  soil_class_t         cls_n, pending, pending_n, cand_c;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                valid_n, changed_n, rail_hold;
  logic [SAMPLE_W-1:0] mean_n;
  logic [CW-1:0]       m_c;

`ifdef SOIL_SENSOR_FAULT_EN
  localparam int unsigned RAIL_W = $clog2(FAULT_WINDOWS + 1);
  logic              fault_q, fault_n;
  logic [RAIL_W-1:0] rail_cnt, rail_cnt_n;
  assign fault = fault_q;
`else
  logic unused_rail;
  assign unused_rail = rail_c | (FAULT_WINDOWS == 0);
  assign fault       = 1'b0;
`endif

  // Candidate class: plain thresholds in INIT, hysteresis around the committed class otherwise.
  always_comb begin
    m_c    = {1'b0, mean_c};
    cand_c = CLASS_OPTIMAL;
    if (state == ST_INIT) begin
      if (m_c < DRY_C)      cand_c = CLASS_DRY;
      else if (m_c > WET_C) cand_c = CLASS_WET;
    end else begin
      case (soil_class)
        CLASS_DRY: begin
          if (m_c >= DRY_HI) cand_c = (m_c > WET_HI) ? CLASS_WET : CLASS_OPTIMAL;
          else               cand_c = CLASS_DRY;
        end
        CLASS_WET: begin
          if (m_c <= WET_LO) cand_c = (m_c < DRY_LO) ? CLASS_DRY : CLASS_OPTIMAL;
          else               cand_c = CLASS_WET;
        end
        default: begin
          if (m_c < DRY_LO)      cand_c = CLASS_DRY;
          else if (m_c > WET_HI) cand_c = CLASS_WET;
        end
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    cls_n     = soil_class;
    pending_n = pending;
    cnt_n     = cnt;
    valid_n   = 1'b0;
    changed_n = 1'b0;
    mean_n    = window_mean;
    rail_hold = 1'b0;
`ifdef SOIL_SENSOR_FAULT_EN
    fault_n    = fault_q;
    rail_cnt_n = rail_cnt;
`endif
    if (flush) begin
      state_n   = ST_INIT;
      cls_n     = CLASS_OPTIMAL;
      pending_n = CLASS_OPTIMAL;
      cnt_n     = '0;
`ifdef SOIL_SENSOR_FAULT_EN
      fault_n    = 1'b0;
      rail_cnt_n = '0;
`endif
    end else if (done_c) begin
      valid_n = 1'b1;
      mean_n  = mean_c;
`ifdef SOIL_SENSOR_FAULT_EN
      // Rail windows count up; reaching the limit forces FAULT and re-initialises.
      if (rail_c) begin
        if (rail_cnt != RAIL_W'(FAULT_WINDOWS)) rail_cnt_n = rail_cnt + RAIL_W'(1);
        if (fault_q) begin
          rail_hold = 1'b1;
        end else if (rail_cnt_n == RAIL_W'(FAULT_WINDOWS)) begin
          rail_hold = 1'b1;
          fault_n   = 1'b1;
          cls_n     = CLASS_FAULT;
          changed_n = 1'b1;
          state_n   = ST_INIT;
          cnt_n     = '0;
        end
      end else begin
        rail_cnt_n = '0;
        fault_n    = 1'b0;
      end
`endif
      if (!rail_hold) begin
        case (state)
          ST_INIT: begin
            cls_n     = cand_c;
            changed_n = (cand_c != soil_class);
            cnt_n     = '0;
            state_n   = ST_TRACK;
          end
          ST_TRACK: begin
            if (cand_c != soil_class) begin
              pending_n = cand_c;
              if (CONFIRM_N == 1) begin
                cls_n     = cand_c;
                changed_n = 1'b1;
                cnt_n     = '0;
              end else begin
                cnt_n   = CNT_W'(1);
                state_n = ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (cand_c == soil_class) begin
              cnt_n   = '0;
              state_n = ST_TRACK;
            end else if (cand_c == pending) begin
              if (cnt + CNT_W'(1) == CNT_W'(CONFIRM_N)) begin
                cls_n     = cand_c;
                changed_n = 1'b1;
                cnt_n     = '0;
                state_n   = ST_TRACK;
              end else begin
                cnt_n = cnt + CNT_W'(1);
              end
            end else begin
              pending_n = cand_c;
              cnt_n     = CNT_W'(1);
            end
          end
          default: state_n = ST_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      soil_class    <= CLASS_OPTIMAL;
      pending       <= CLASS_OPTIMAL;
      cnt           <= '0;
      class_valid   <= 1'b0;
      class_changed <= 1'b0;
      window_mean   <= '0;
    end else begin
      state         <= state_n;
      soil_class    <= cls_n;
      pending       <= pending_n;
      cnt           <= cnt_n;
      class_valid   <= valid_n;
      class_changed <= changed_n;
      window_mean   <= mean_n;
    end
  end

`ifdef SOIL_SENSOR_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q  <= 1'b0;
      rail_cnt <= '0;
    end else begin
      fault_q  <= fault_n;
      rail_cnt <= rail_cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_soil_moisture_classifier.sv
// Directed self-checking bench for soil_moisture_classifier (default parameters).
// Fault scenario runs only when SOIL_SENSOR_FAULT_EN is defined.
module tb_soil_moisture_classifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic        flush = 1'b0;
  logic [1:0]  soil_class;
  logic        class_valid;
  logic        class_changed;
  logic [11:0] window_mean;
  logic        fault;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  soil_moisture_classifier dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .flush         (flush),
    .soil_class    (soil_class),
    .class_valid   (class_valid),
    .class_changed (class_changed),
    .window_mean   (window_mean),
    .fault         (fault)
  );

  // Observed tuple {class, class_valid, class_changed, fault}.
  logic [4:0] obs;
  assign obs = {soil_class, class_valid, class_changed, fault};

  task automatic put(input logic [11:0] v);
    @(negedge clk);
    sample_valid = 1'b1;
    sample       = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic window(input logic [11:0] v);
    for (int i = 0; i < 4; i++) put(v);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 5'b01_0_0_0) $display("FAIL reset_flags got %b want %b", obs, 5'b01_0_0_0);
    else passed++;
    total++;
    if (window_mean !== 12'd0) $display("FAIL reset_mean got %0d want 0", window_mean);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_window();
    window(12'd500);
    total++;
    if (obs !== 5'b00_1_1_0) $display("FAIL first_window got %b want %b", obs, 5'b00_1_1_0);
    else passed++;
    total++;
    if (window_mean !== 12'd500) $display("FAIL first_mean got %0d want 500", window_mean);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (obs !== 5'b00_0_0_0) $display("FAIL first_pulse_width got %b want %b", obs, 5'b00_0_0_0);
    else passed++;
  endtask

  task automatic test_dry_hysteresis();
    for (int w = 0; w < 3; w++) begin
      window(12'd1050);
      total++;
      if (obs !== 5'b00_1_0_0) $display("FAIL dry_hold_%0d got %b want %b", w, obs, 5'b00_1_0_0);
      else passed++;
    end
    window(12'd1150);
    total++;
    if (obs !== 5'b00_1_0_0) $display("FAIL dry_pending got %b want %b", obs, 5'b00_1_0_0);
    else passed++;
    window(12'd1150);
    total++;
    if (obs !== 5'b01_1_1_0) $display("FAIL dry_to_opt got %b want %b", obs, 5'b01_1_1_0);
    else passed++;
    total++;
    if (window_mean !== 12'd1150) $display("FAIL dry_to_opt_mean got %0d want 1150", window_mean);
    else passed++;
  endtask

  task automatic test_opt_to_wet();
    logic [4:0] exp_t [4];
    logic [11:0] vals [4];
    vals[0] = 12'd3200; vals[1] = 12'd2000; vals[2] = 12'd3200; vals[3] = 12'd3200;
    exp_t[0] = 5'b01_1_0_0; exp_t[1] = 5'b01_1_0_0; exp_t[2] = 5'b01_1_0_0; exp_t[3] = 5'b10_1_1_0;
    do_flush();
    window(12'd2000);
    total++;
    if (obs !== 5'b01_1_0_0) $display("FAIL opt_init got %b want %b", obs, 5'b01_1_0_0);
    else passed++;
    for (int w = 0; w < 4; w++) begin
      window(vals[w]);
      total++;
      if (obs !== exp_t[w]) $display("FAIL opt_wet_%0d got %b want %b", w, obs, exp_t[w]);
      else passed++;
    end
    @(posedge clk);
    #1;
    total++;
    if (class_changed !== 1'b0) $display("FAIL opt_wet_single_pulse got %b want 0", class_changed);
    else passed++;
  endtask

  task automatic test_truncation();
    do_flush();
    put(12'd1); put(12'd1); put(12'd1); put(12'd2);
    total++;
    if (window_mean !== 12'd1) $display("FAIL trunc_mean got %0d want 1", window_mean);
    else passed++;
    total++;
    if (obs !== 5'b00_1_1_0) $display("FAIL trunc_class got %b want %b", obs, 5'b00_1_1_0);
    else passed++;
    window(12'd4095);
    total++;
    if (window_mean !== 12'd4095) $display("FAIL full_scale_mean got %0d want 4095", window_mean);
    else passed++;
    total++;
    if (obs !== 5'b00_1_0_0) $display("FAIL full_scale_class got %b want %b", obs, 5'b00_1_0_0);
    else passed++;
  endtask

  task automatic test_flush_mid_window();
    do_flush();
    put(12'd500); put(12'd500);
    @(negedge clk);
    flush = 1'b1;
    sample_valid = 1'b1;
    sample = 12'd500;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sample_valid = 1'b0;
    total++;
    if (obs !== 5'b01_0_0_0) $display("FAIL flush_state got %b want %b", obs, 5'b01_0_0_0);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      put(12'd500);
      total++;
      if (class_valid !== 1'b0) $display("FAIL flush_early_valid_%0d got %b want 0", i, class_valid);
      else passed++;
    end
    put(12'd500);
    total++;
    if (obs !== 5'b00_1_1_0) $display("FAIL flush_window got %b want %b", obs, 5'b00_1_1_0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int i = 0; i < 8; i++) begin
      put(12'd1500);
      exp_v = (i % 4 == 3);
      total++;
      if (class_valid !== exp_v) $display("FAIL b2b_valid_%0d got %b want %b", i, class_valid, exp_v);
      else passed++;
    end
    total++;
    if (obs !== 5'b01_1_1_0) $display("FAIL b2b_commit got %b want %b", obs, 5'b01_1_1_0);
    else passed++;
  endtask

`ifdef SOIL_SENSOR_FAULT_EN
  task automatic test_fault();
    do_flush();
    window(12'd4095);
    total++;
    if (obs !== 5'b10_1_1_0) $display("FAIL fault_first_rail got %b want %b", obs, 5'b10_1_1_0);
    else passed++;
    window(12'd4095);
    total++;
    if (obs !== 5'b11_1_1_1) $display("FAIL fault_set got %b want %b", obs, 5'b11_1_1_1);
    else passed++;
    window(12'd2000);
    total++;
    if (obs !== 5'b01_1_1_0) $display("FAIL fault_clear got %b want %b", obs, 5'b01_1_1_0);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_window();
    test_dry_hysteresis();
    test_opt_to_wet();
    test_truncation();
    test_flush_mid_window();
    test_back_to_back();
`ifdef SOIL_SENSOR_FAULT_EN
    test_fault();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
